// File: rtl/icache_itlb_if.sv
// Fetch-side bundle between the PC logic / memory arbiter and icache_itlb.
// master = fetch + memory side, slave = the cache block.
interface icache_itlb_if;
  logic         req_valid;
  logic [31:0]  req_virt_addr;
  logic         priv_mode;
  logic         icache_ready;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_tlb_miss;
  logic         rsp_bus_error;
  logic         req_valid_miss;
  logic [19:0]  req_miss_addr;
  logic         rsp_valid_miss;
  logic [127:0] rsp_data_miss;
  logic         rsp_bus_error_miss;
  logic         new_tlb_entry;
  logic [19:0]  new_tlb_virt_page;
  logic [7:0]   new_tlb_phy_page;
  logic         new_tlb_write_priv;

  modport master (
    output req_valid, req_virt_addr, priv_mode,
    input  icache_ready, rsp_valid, rsp_data, rsp_tlb_miss, rsp_bus_error,
    input  req_valid_miss, req_miss_addr,
    output rsp_valid_miss, rsp_data_miss, rsp_bus_error_miss,
    output new_tlb_entry, new_tlb_virt_page, new_tlb_phy_page, new_tlb_write_priv
  );

  modport slave (
    input  req_valid, req_virt_addr, priv_mode,
    output icache_ready, rsp_valid, rsp_data, rsp_tlb_miss, rsp_bus_error,
    output req_valid_miss, req_miss_addr,
    input  rsp_valid_miss, rsp_data_miss, rsp_bus_error_miss,
    input  new_tlb_entry, new_tlb_virt_page, new_tlb_phy_page, new_tlb_write_priv
  );
endinterface

// File: rtl/icache_itlb.sv
// iTLB + direct-mapped I-cache returning whole 128-bit lines; ICACHE_VERBOSE_EN adds sim messages.
// Latency: hit / iTLB miss respond one cycle after accept; refill responds one cycle after rsp_valid_miss.
// Backpressure: icache_ready drops from the cycle after a cache miss until the refill response is taken.
module icache_itlb #(
  parameter int TLB_ENTRIES  = 4,
  parameter int ICACHE_LINES = 4
) (
  input  logic         clock,
  input  logic         reset,
  icache_itlb_if.slave bus
);

  localparam int TW = (TLB_ENTRIES  > 1) ? $clog2(TLB_ENTRIES)  : 1;
  localparam int IW = (ICACHE_LINES > 1) ? $clog2(ICACHE_LINES) : 1;
  localparam int GW = 16 - IW;

  typedef struct packed {
    logic        vld;
    logic [19:0] vpn;
    logic [7:0]  ppn;
    logic        wpriv;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

  tlb_entry_t              tlb_q [TLB_ENTRIES];
  logic [TW-1:0]           rr_ptr;
  logic [ICACHE_LINES-1:0] line_vld;
  logic [GW-1:0]           line_tag [ICACHE_LINES];
  logic [127:0]            line_dat [ICACHE_LINES];
  state_t                  state;

  logic          tlb_hit;
  logic [7:0]    hit_ppn;
  logic [15:0]   phy_line;
  logic [IW-1:0] lk_idx;
  logic [GW-1:0] lk_tag;
  logic          cache_hit;
  logic [IW-1:0] rf_idx;
  logic [GW-1:0] rf_tag;
  logic          refill_done;

  always_comb begin
    tlb_hit = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_q[i].vld && (tlb_q[i].vpn == bus.req_virt_addr[31:12])) begin
        tlb_hit = 1'b1;
        hit_ppn = tlb_q[i].ppn;
      end
    end
  end

  // Physical address bits [19:4]; supervisor fetches bypass translation.
  assign phy_line  = bus.priv_mode ? bus.req_virt_addr[19:4]
                                   : {hit_ppn, bus.req_virt_addr[11:4]};
  assign lk_idx    = phy_line[IW-1:0];
  assign lk_tag    = phy_line[15:IW];
  assign cache_hit = line_vld[lk_idx] && (line_tag[lk_idx] == lk_tag);

  assign rf_idx      = bus.req_miss_addr[4 +: IW];
  assign rf_tag      = bus.req_miss_addr[19:4+IW];
  assign refill_done = (state == MISS_WAIT) && bus.rsp_valid_miss;

  // iTLB write slot: existing VPN, else lowest free entry, else round-robin victim.
  logic          wr_match, wr_free;
  logic [TW-1:0] match_idx, free_idx, wr_idx;

  always_comb begin
    wr_match  = 1'b0;
    wr_free   = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_q[i].vld && (tlb_q[i].vpn == bus.new_tlb_virt_page)) begin
        wr_match  = 1'b1;
        match_idx = TW'(i);
      end
      if (!tlb_q[i].vld) begin
        wr_free  = 1'b1;
        free_idx = TW'(i);
      end
    end
    wr_idx = wr_match ? match_idx : (wr_free ? free_idx : rr_ptr);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      line_vld           <= '0;
      bus.icache_ready   <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_data       <= '0;
      bus.rsp_tlb_miss   <= 1'b0;
      bus.rsp_bus_error  <= 1'b0;
      bus.req_valid_miss <= 1'b0;
      bus.req_miss_addr  <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
    end else begin
      bus.rsp_valid      <= 1'b0;
      bus.rsp_tlb_miss   <= 1'b0;
      bus.rsp_bus_error  <= 1'b0;
      bus.req_valid_miss <= 1'b0;

      if (bus.new_tlb_entry) begin
        tlb_q[wr_idx] <= '{vld: 1'b1, vpn: bus.new_tlb_virt_page,
                           ppn: bus.new_tlb_phy_page, wpriv: bus.new_tlb_write_priv};
        if (!wr_match && !wr_free)
          rr_ptr <= (rr_ptr == TW'(TLB_ENTRIES - 1)) ? '0 : rr_ptr + TW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!bus.priv_mode && !tlb_hit) begin
              bus.rsp_valid    <= 1'b1;
              bus.rsp_tlb_miss <= 1'b1;
            end else if (cache_hit) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= line_dat[lk_idx];
            end else begin
              bus.req_miss_addr  <= {phy_line, 4'h0};
              bus.req_valid_miss <= 1'b1;
              bus.icache_ready   <= 1'b0;
              state              <= MISS_REQ;
            end
          end
        end
        MISS_REQ: state <= MISS_WAIT;
        MISS_WAIT: begin
          if (bus.rsp_valid_miss) begin
            bus.rsp_valid      <= 1'b1;
            bus.rsp_bus_error  <= bus.rsp_bus_error_miss;
            bus.rsp_data       <= bus.rsp_data_miss;
            line_vld[rf_idx]   <= !bus.rsp_bus_error_miss;
            bus.icache_ready   <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: the valid bits guard it.
  always_ff @(posedge clock) begin
    if (refill_done && !bus.rsp_bus_error_miss) begin
      line_tag[rf_idx] <= rf_tag;
      line_dat[rf_idx] <= bus.rsp_data_miss;
    end
  end

`ifdef ICACHE_VERBOSE_EN
  always @(posedge clock) begin
    if (reset) begin
      if (state == IDLE && bus.req_valid && !bus.priv_mode && !tlb_hit)
        $display("icache_itlb: itlb miss vpn=%05h", bus.req_virt_addr[31:12]);
      if (state == IDLE && bus.req_valid && (bus.priv_mode || tlb_hit) && !cache_hit)
        $display("icache_itlb: cache miss pa=%05h", {phy_line, 4'h0});
      if (refill_done)
        $display("icache_itlb: refill pa=%05h data=%032h err=%0b",
                 bus.req_miss_addr, bus.rsp_data_miss, bus.rsp_bus_error_miss);
      if (bus.new_tlb_entry)
        $display("icache_itlb: itlb write vpn=%05h ppn=%02h entry=%0d",
                 bus.new_tlb_virt_page, bus.new_tlb_phy_page, wr_idx);
    end
  end
`else
  // Quiet build: no simulation messages, identical behaviour.
`endif

endmodule

// File: tb/tb_icache_itlb.sv
// Directed bench for icache_itlb: a behavioural model checked every cycle on the falling edge,
// plus literal expectations at the key points of each scenario.
module tb_icache_itlb;
  localparam int NT = 4;
  localparam int NL = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  icache_itlb_if bus_if ();

  icache_itlb #(.TLB_ENTRIES(NT), .ICACHE_LINES(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_vld [NT];
  logic [19:0]  m_vpn [NT];
  logic [7:0]   m_ppn [NT];
  int           m_rr;
  logic         c_vld [NL];
  logic [15:0]  c_la  [NL];
  logic [127:0] c_data[NL];
  logic         m_pending, m_fresh;
  logic [15:0]  m_la;
  logic         e_ready, e_rsp_valid, e_tlb_miss, e_berr, e_rvm;
  logic [127:0] e_data;
  logic [19:0]  e_addr;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < NL; i++) c_vld[i] = 1'b0;
    m_rr = 0; m_pending = 1'b0; m_fresh = 1'b0; m_la = '0;
    e_ready = 1'b1; e_rsp_valid = 1'b0; e_tlb_miss = 1'b0; e_berr = 1'b0; e_rvm = 1'b0;
    e_data = '0; e_addr = '0;
  endtask

  task automatic model_step();
    logic [19:0] pa;
    logic        hit;
    logic [15:0] la;
    int          idx, wi;
    e_rsp_valid = 1'b0; e_tlb_miss = 1'b0; e_berr = 1'b0; e_rvm = 1'b0;
    if (!m_pending) begin
      if (bus_if.req_valid) begin
        hit = bus_if.priv_mode;
        pa  = bus_if.req_virt_addr[19:0];
        if (!bus_if.priv_mode)
          for (int i = 0; i < NT; i++)
            if (m_vld[i] && m_vpn[i] == bus_if.req_virt_addr[31:12]) begin
              hit = 1'b1;
              pa  = {m_ppn[i], bus_if.req_virt_addr[11:0]};
            end
        if (!hit) begin
          e_rsp_valid = 1'b1; e_tlb_miss = 1'b1;
        end else begin
          la  = pa[19:4];
          idx = int'(la) % NL;
          if (c_vld[idx] && c_la[idx] == la) begin
            e_rsp_valid = 1'b1; e_data = c_data[idx];
          end else begin
            m_pending = 1'b1; m_fresh = 1'b1; m_la = la;
            e_rvm = 1'b1; e_addr = {la, 4'h0}; e_ready = 1'b0;
          end
        end
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (bus_if.rsp_valid_miss) begin
      idx = int'(m_la) % NL;
      e_rsp_valid = 1'b1; e_berr = bus_if.rsp_bus_error_miss; e_data = bus_if.rsp_data_miss;
      c_vld[idx] = !bus_if.rsp_bus_error_miss; c_la[idx] = m_la; c_data[idx] = bus_if.rsp_data_miss;
      m_pending = 1'b0; e_ready = 1'b1;
    end
    if (bus_if.new_tlb_entry) begin
      wi = -1;
      for (int i = 0; i < NT; i++)
        if (m_vld[i] && m_vpn[i] == bus_if.new_tlb_virt_page) wi = i;
      if (wi < 0)
        for (int i = NT - 1; i >= 0; i--) if (!m_vld[i]) wi = i;
      if (wi < 0) begin
        wi = m_rr; m_rr = (m_rr + 1) % NT;
      end
      m_vld[wi] = 1'b1; m_vpn[wi] = bus_if.new_tlb_virt_page; m_ppn[wi] = bus_if.new_tlb_phy_page;
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      model_reset();
      chk("reset icache_ready",   bus_if.icache_ready,   1'b1);
      chk("reset rsp_valid",      bus_if.rsp_valid,      1'b0);
      chk("reset req_valid_miss", bus_if.req_valid_miss, 1'b0);
      chk("reset rsp_data",       bus_if.rsp_data,       128'h0);
      chk("reset req_miss_addr",  bus_if.req_miss_addr,  20'h0);
    end else begin
      chk("icache_ready",   bus_if.icache_ready,   e_ready);
      chk("rsp_valid",      bus_if.rsp_valid,      e_rsp_valid);
      chk("rsp_tlb_miss",   bus_if.rsp_tlb_miss,   e_tlb_miss);
      chk("rsp_bus_error",  bus_if.rsp_bus_error,  e_berr);
      chk("req_valid_miss", bus_if.req_valid_miss, e_rvm);
      if (e_rsp_valid && !e_tlb_miss && !e_berr) chk("rsp_data", bus_if.rsp_data, e_data);
      if (e_rvm) chk("req_miss_addr", bus_if.req_miss_addr, e_addr);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] va, input logic pm);
    bus_if.req_valid = 1'b1; bus_if.req_virt_addr = va; bus_if.priv_mode = pm;
    tick();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic refill(input logic [127:0] d, input logic err);
    tick();
    bus_if.rsp_valid_miss = 1'b1; bus_if.rsp_data_miss = d; bus_if.rsp_bus_error_miss = err;
    tick();
    bus_if.rsp_valid_miss = 1'b0; bus_if.rsp_bus_error_miss = 1'b0;
  endtask

  task automatic tlb_wr(input logic [19:0] vpn, input logic [7:0] ppn);
    bus_if.new_tlb_entry = 1'b1; bus_if.new_tlb_virt_page = vpn; bus_if.new_tlb_phy_page = ppn;
    bus_if.new_tlb_write_priv = 1'b0;
    tick();
    bus_if.new_tlb_entry = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  localparam logic [127:0] DA = {32{4'hA}};
  localparam logic [127:0] DB = {32{4'hB}};
  localparam logic [127:0] DC = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DD = {16{8'h5D}};

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid = 1'b0; bus_if.req_virt_addr = '0; bus_if.priv_mode = 1'b0;
    bus_if.rsp_valid_miss = 1'b0; bus_if.rsp_data_miss = '0; bus_if.rsp_bus_error_miss = 1'b0;
    bus_if.new_tlb_entry = 1'b0; bus_if.new_tlb_virt_page = '0; bus_if.new_tlb_phy_page = '0;
    bus_if.new_tlb_write_priv = 1'b0;
    tick(); tick();
    chk("lit ready in reset", bus_if.icache_ready, 1'b1);
    reset = 1'b1;
    tick();

    // Supervisor cold miss, refill, then hits including back-to-back.
    fetch(32'h0000_1000, 1'b1);
    chk("lit sup miss pulse", bus_if.req_valid_miss, 1'b1);
    chk("lit sup miss addr",  bus_if.req_miss_addr,  20'h01000);
    chk("lit ready low",      bus_if.icache_ready,   1'b0);
    refill(DA, 1'b0);
    chk("lit refill valid", bus_if.rsp_valid,    1'b1);
    chk("lit refill data",  bus_if.rsp_data,     DA);
    chk("lit refill ready", bus_if.icache_ready, 1'b1);
    fetch(32'h0000_1004, 1'b1);
    chk("lit rehit valid", bus_if.rsp_valid,      1'b1);
    chk("lit rehit data",  bus_if.rsp_data,       DA);
    chk("lit rehit nomiss", bus_if.req_valid_miss, 1'b0);
    bus_if.req_valid = 1'b1; bus_if.req_virt_addr = 32'h0000_1008; tick();
    chk("lit b2b 1", bus_if.rsp_valid, 1'b1);
    bus_if.req_virt_addr = 32'h0000_100C; tick();
    chk("lit b2b 2", bus_if.rsp_valid, 1'b1);
    bus_if.req_valid = 1'b0;
    tick();

    // User fetch with an empty iTLB.
    fetch(32'h0000_8000, 1'b0);
    chk("lit tlb miss",        bus_if.rsp_tlb_miss,   1'b1);
    chk("lit tlb miss nofill", bus_if.req_valid_miss, 1'b0);

    // Install VPN 8 -> PPN 3 and fetch through it.
    tlb_wr(20'h00008, 8'h03);
    fetch(32'h0000_8010, 1'b0);
    chk("lit user miss addr", bus_if.req_miss_addr, 20'h03010);
    refill(DB, 1'b0);
    fetch(32'h0000_801C, 1'b0);
    chk("lit user hit data", bus_if.rsp_data, DB);

    // Lookup in the same cycle as a write sees the old table.
    bus_if.new_tlb_entry = 1'b1; bus_if.new_tlb_virt_page = 20'h00009; bus_if.new_tlb_phy_page = 8'h04;
    fetch(32'h0000_9000, 1'b0);
    bus_if.new_tlb_entry = 1'b0;
    chk("lit same-cycle write miss", bus_if.rsp_tlb_miss, 1'b1);
    fetch(32'h0000_9000, 1'b0);
    chk("lit after-write addr", bus_if.req_miss_addr, 20'h04000);
    refill(DC, 1'b0);

    // Refill bus error leaves the line invalid.
    fetch(32'h0000_2020, 1'b1);
    refill(DD, 1'b1);
    chk("lit bus error", bus_if.rsp_bus_error, 1'b1);
    fetch(32'h0000_2020, 1'b1);
    chk("lit refetch misses", bus_if.req_valid_miss, 1'b1);
    refill(DD, 1'b0);
    fetch(32'h0000_2024, 1'b1);
    chk("lit refetch hit data", bus_if.rsp_data, DD);

    // Round-robin replacement from an empty iTLB.
    do_reset();
    for (int i = 0; i < 5; i++) tlb_wr(20'h00010 + 20'(i), 8'h20 + 8'(i));
    fetch(32'h0001_0000, 1'b0);
    chk("lit rr victim", bus_if.rsp_tlb_miss, 1'b1);
    fetch(32'h0001_1040, 1'b0);
    chk("lit rr keep addr", bus_if.req_miss_addr, 20'h21040);
    refill(DA, 1'b0);
    fetch(32'h0001_4000, 1'b0);
    chk("lit rr fifth addr", bus_if.req_miss_addr, 20'h24000);
    refill(DB, 1'b0);
    tlb_wr(20'h00012, 8'h55);
    fetch(32'h0001_2080, 1'b0);
    chk("lit overwrite addr", bus_if.req_miss_addr, 20'h55080);
    refill(DC, 1'b0);

    // Reset in the middle of a refill, then a stray refill response.
    fetch(32'h0000_3000, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus_if.rsp_valid_miss = 1'b1; bus_if.rsp_data_miss = DD;
    tick();
    bus_if.rsp_valid_miss = 1'b0;
    chk("lit stray no rsp", bus_if.rsp_valid,    1'b0);
    chk("lit stray ready",  bus_if.icache_ready, 1'b1);
    fetch(32'h0000_3000, 1'b1);
    chk("lit line invalid", bus_if.req_valid_miss, 1'b1);
    refill(DB, 1'b0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
